inst_fetch_unit: RTL

- Fetch stage directly upstream of the control unit in the 16-bit single-cycle CPU.
- Owns the PC and runs the instruction-memory read handshake (readM/inputReady).
- Latches the fetched word into an instruction register and slices it into opcode/func/register/immediate/target fields for the control unit and datapath.
- Takes the control unit's isJMP back to select the next PC, and counts retired instructions.

---
 rtl/cpu_defs_pkg.sv | 47 ++++
 rtl/inst_field_split.sv | 24 ++
 rtl/inst_fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: word size, opcode and
// function codes, fetch state encoding and instruction field positions.
package cpu_defs;

    localparam int WORD_SIZE = 16;

    // Opcodes (instr[15:12])
    localparam logic [3:0] OPCODE_ADI   = 4'd4;
    localparam logic [3:0] OPCODE_LHI   = 4'd6;
    localparam logic [3:0] OPCODE_JMP   = 4'd9;
    localparam logic [3:0] OPCODE_JAL   = 4'd10;
    localparam logic [3:0] OPCODE_RTYPE = 4'd15;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_WWD = 6'd28;
    localparam logic [5:0] FUNC_HLT = 6'd29;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RS_MSB     = 11;
    localparam int RS_LSB     = 10;
    localparam int RT_MSB     = 9;
    localparam int RT_LSB     = 8;
    localparam int RD_MSB     = 7;
    localparam int RD_LSB     = 6;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 11;
    localparam int TARGET_LSB = 0;

    // Fetch state encoding
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // True for the HLT instruction (R-type with FUNC_HLT)
    function automatic logic is_hlt(input logic [3:0] op, input logic [5:0] fn);
        return (op == OPCODE_RTYPE) && (fn == FUNC_HLT);
    endfunction

endpackage

// File: rtl/inst_field_split.sv
// Combinational slicing of an instruction word into its decode fields.
// Shared by single-cycle, multi-cycle and pipelined fetch variants.
module inst_field_split
    import cpu_defs::*;
(
    input  logic [WORD_SIZE-1:0] i_instr,
    output logic [3:0]           o_opcode,
    output logic [5:0]           o_func,
    output logic [1:0]           o_rs,
    output logic [1:0]           o_rt,
    output logic [1:0]           o_rd,
    output logic [7:0]           o_imm,
    output logic [11:0]          o_target
);

    assign o_opcode = i_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_func   = i_instr[FUNC_MSB:FUNC_LSB];
    assign o_rs     = i_instr[RS_MSB:RS_LSB];
    assign o_rt     = i_instr[RT_MSB:RT_LSB];
    assign o_rd     = i_instr[RD_MSB:RD_LSB];
    assign o_imm    = i_instr[IMM_MSB:IMM_LSB];
    assign o_target = i_instr[TARGET_MSB:TARGET_LSB];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, runs the readM/inputReady handshake, holds the
// instruction register and counts retired instructions.
// Optional: define HALT_INST_EN to make HLT stop fetching until reset.
module inst_fetch_unit
    import cpu_defs::*;
#(
    parameter int                         WORD_SIZE = cpu_defs::WORD_SIZE,
    parameter logic [cpu_defs::WORD_SIZE-1:0] RESET_PC  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 readM,
    output logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] memData,
    input  logic                 inputReady,
    input  logic                 isJMP,
    output logic [WORD_SIZE-1:0] instr,
    output logic [3:0]           opcode,
    output logic [5:0]           func,
    output logic [1:0]           rs,
    output logic [1:0]           rt,
    output logic [1:0]           rd,
    output logic [7:0]           imm,
    output logic [11:0]          target,
    output logic                 instValid,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 halted
);

    fetch_state_t         r_state;
    fetch_state_t         w_next_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_instr;
    logic [WORD_SIZE-1:0] r_num_inst;
    logic                 r_read_m;
    logic                 w_load_instr;
    logic                 w_retire;
    logic                 w_advance_pc;
    logic [WORD_SIZE-1:0] w_next_pc;

    inst_field_split u_split (
        .i_instr  (r_instr),
        .o_opcode (opcode),
        .o_func   (func),
        .o_rs     (rs),
        .o_rt     (rt),
        .o_rd     (rd),
        .o_imm    (imm),
        .o_target (target)
    );

    // Next-state and datapath strobes for the fetch FSM
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_load_instr = 1'b0;
        w_retire     = 1'b0;
        w_advance_pc = 1'b0;
        case (r_state)
            FETCH: begin
                // r_read_m is low for the first cycle after reset; strobes there are ignored
                if (r_read_m && inputReady) begin
                    w_load_instr = 1'b1;
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                w_retire     = 1'b1;
                w_advance_pc = 1'b1;
                w_next_state = FETCH;
`ifdef HALT_INST_EN
                if (is_hlt(opcode, func)) begin
                    w_advance_pc = 1'b0;
                    w_next_state = HALTED;
                end
`endif
            end
            HALTED:  w_next_state = HALTED;
            default: w_next_state = FETCH;
        endcase
    end

    // Next PC: jump keeps the upper bits of the current pc, otherwise increment with wrap
    always_comb begin
        w_next_pc = r_pc + 1'b1;
        if (isJMP)
            w_next_pc = {r_pc[WORD_SIZE-1:12], target};
    end

    // State, PC, instruction register, retire counter and read request
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_num_inst <= '0;
            r_read_m   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_read_m <= (w_next_state == FETCH);
            if (w_load_instr)
                r_instr <= memData;
            if (w_retire)
                r_num_inst <= r_num_inst + 1'b1;
            if (w_advance_pc)
                r_pc <= w_next_pc;
        end
    end

    assign readM     = r_read_m;
    assign address   = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign num_inst  = r_num_inst;
    assign instValid = (r_state == DECODE);
`ifdef HALT_INST_EN
    assign halted    = (r_state == HALTED);
`else
    assign halted    = 1'b0;
`endif

endmodule
